// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_gen pseudo-random source.
//   lfsr_state_e      : controller states (IDLE, BURST, RECOVER)
//   lfsr_default_taps : maximal-length XNOR tap masks for widths 8..16
//   lfsr_next         : one Fibonacci XNOR shift step on a 32-bit container;
//                       callers keep the low WIDTH bits (WIDTH <= 32)
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RECOVER = 2'd2
    } lfsr_state_e;

    // Bit i set means ps[i] feeds the XNOR. Widths outside the table get 0,
    // so the instantiating module must then supply its own TAPS.
    function automatic logic [31:0] lfsr_default_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

    // Bits above the register width are zero in ps and taps, so they never
    // disturb the feedback; the shifted-out top bit is dropped by the caller.
    function automatic logic [31:0] lfsr_next(input logic [31:0] ps,
                                              input logic [31:0] taps);
        logic fb;
        fb = ~^(ps & taps);
        return {ps[30:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// XNOR Fibonacci LFSR with seed load, free-run enable, counted bursts and
// automatic lock-up recovery.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   en          : free-run step enable (IDLE only)
//   load        : load seed_in this cycle (highest priority after reset)
//   seed_in     : seed value
//   burst_start : start a counted burst (accepted in IDLE only)
//   burst_len   : number of steps in the burst
//   out         : current register value
//   busy        : high while a burst is in progress
//   done        : one-cycle pulse after a burst completes
//   lockup      : high during the cycle out is all-ones
//
// state   | meaning
// IDLE    | free-run stepping on en, waiting for burst_start
// BURST   | stepping every cycle, cnt counts remaining steps
// RECOVER | register is all-ones; next edge reloads SEED without stepping,
//         | then returns to IDLE or BURST (ret_burst_q)
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             lockup
);

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ret_burst_q, ret_burst_d;
    logic             done_q, done_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] ps_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ps_q        <= '0;
            cnt_q       <= '0;
            ret_burst_q <= 1'b0;
            done_q      <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ps_q        <= ps_d;
            cnt_q       <= cnt_d;
            ret_burst_q <= ret_burst_d;
            done_q      <= done_d;
            lockup_q    <= lockup_d;
        end
    end

    always_comb begin
        ps_step     = WIDTH'(lfsr_next(32'(ps_q), 32'(TAPS)));
        ps_d        = ps_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        ret_burst_d = ret_burst_q;
        done_d      = 1'b0;

        if (load) begin
            ps_d        = seed_in;
            state_d     = IDLE;
            cnt_d       = '0;
            ret_burst_d = 1'b0;
        end else begin
            case (state_q)
                RECOVER: begin
                    // cnt is left untouched so an interrupted burst resumes
                    ps_d        = SEED;
                    state_d     = ret_burst_q ? BURST : IDLE;
                    ret_burst_d = 1'b0;
                end
                BURST: begin
                    ps_d  = ps_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                IDLE: begin
                    if (burst_start) begin
                        if (burst_len != '0) begin
                            cnt_d   = burst_len;
                            state_d = BURST;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (en) begin
                        ps_d = ps_step;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // All-ones is a fixed point of the XNOR feedback: divert to RECOVER,
        // remembering whether a burst must continue afterwards.
        lockup_d = &ps_d;
        if (lockup_d) begin
            ret_burst_d = (state_d == BURST);
            state_d     = RECOVER;
        end
    end

    always_comb begin
        out    = ps_q;
        done   = done_q;
        lockup = lockup_q;
        busy   = (state_q == BURST) || ((state_q == RECOVER) && ret_burst_q);
    end

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [9:0]  seed_in;
    logic        burst_start;
    logic [15:0] burst_len;
    logic [9:0]  out;
    logic        busy;
    logic        done;
    logic        lockup;

    int tests_run    = 0;
    int tests_failed = 0;

    lfsr_gen dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .load        (load),
        .seed_in     (seed_in),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .out         (out),
        .busy        (busy),
        .done        (done),
        .lockup      (lockup)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        en          = 1'b0;
        load        = 1'b0;
        seed_in     = '0;
        burst_start = 1'b0;
        burst_len   = '0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({out, busy, done, lockup} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got out=%h busy=%b done=%b lockup=%b, expected all zero",
                     out, busy, done, lockup);
        end
    endtask

    task automatic test_free_run();
        logic [9:0] exp_seq [11] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F,
                                     10'h07F, 10'h0FE, 10'h1FC, 10'h3F8, 10'h3F1};
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            tests_run++;
            if (out !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL free_run[%0d]: got %h expected %h", i, out, exp_seq[i]);
            end
        end
        en = 1'b0;
        step();
        tests_run++;
        if (out !== 10'h3F1) begin
            tests_failed++;
            $display("FAIL free_run_hold: got %h expected 3f1", out);
        end
    endtask

    task automatic test_period();
        int first_zero = 0;
        apply_reset();
        en = 1'b1;
        for (int i = 1; i <= 1023; i++) begin
            step();
            if (out == 10'h000 && first_zero == 0) first_zero = i;
        end
        en = 1'b0;
        tests_run++;
        if (first_zero != 1023) begin
            tests_failed++;
            $display("FAIL period: first return to 000 at step %0d expected 1023", first_zero);
        end
    endtask

    task automatic test_burst();
        logic [9:0] exp_seq [5] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F};
        apply_reset();
        en          = 1'b0;
        burst_start = 1'b1;
        burst_len   = 16'd5;
        step();
        burst_start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || out !== 10'h000 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_accept: got busy=%b out=%h done=%b expected 1 000 0", busy, out, done);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (out !== exp_seq[i] || busy !== (i < 4) || done !== (i == 4)) begin
                tests_failed++;
                $display("FAIL burst_step[%0d]: got out=%h busy=%b done=%b expected %h %b %b",
                         i, out, busy, done, exp_seq[i], (i < 4), (i == 4));
            end
        end
        step();
        tests_run++;
        if (out !== 10'h01F || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_after: got out=%h busy=%b done=%b expected 01f 0 0", out, busy, done);
        end
        burst_start = 1'b1;
        burst_len   = 16'd0;
        step();
        burst_start = 1'b0;
        tests_run++;
        if (out !== 10'h01F || busy !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_zero: got out=%h busy=%b done=%b expected 01f 0 1", out, busy, done);
        end
        step();
        tests_run++;
        if (out !== 10'h01F || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_zero_after: got out=%h done=%b expected 01f 0", out, done);
        end
    endtask

    task automatic test_burst_ignore();
        apply_reset();
        burst_start = 1'b1;
        burst_len   = 16'd3;
        step();
        burst_start = 1'b0;
        step();
        burst_start = 1'b1;
        burst_len   = 16'd20;
        step();
        burst_start = 1'b0;
        tests_run++;
        if (out !== 10'h003 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_mid: got out=%h busy=%b expected 003 1", out, busy);
        end
        step();
        tests_run++;
        if (out !== 10'h007 || busy !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_end: got out=%h busy=%b done=%b expected 007 0 1", out, busy, done);
        end
    endtask

    task automatic test_lockup();
        apply_reset();
        load    = 1'b1;
        seed_in = 10'h3FF;
        step();
        load = 1'b0;
        tests_run++;
        if (out !== 10'h3FF || lockup !== 1'b1) begin
            tests_failed++;
            $display("FAIL lockup_flag: got out=%h lockup=%b expected 3ff 1", out, lockup);
        end
        en = 1'b1;
        step();
        tests_run++;
        if (out !== 10'h000 || lockup !== 1'b0) begin
            tests_failed++;
            $display("FAIL lockup_recover: got out=%h lockup=%b expected 000 0", out, lockup);
        end
        step();
        tests_run++;
        if (out !== 10'h001) begin
            tests_failed++;
            $display("FAIL lockup_resume1: got %h expected 001", out);
        end
        step();
        en = 1'b0;
        tests_run++;
        if (out !== 10'h003) begin
            tests_failed++;
            $display("FAIL lockup_resume2: got %h expected 003", out);
        end
    endtask

    task automatic test_load_abort();
        apply_reset();
        burst_start = 1'b1;
        burst_len   = 16'd10;
        step();
        burst_start = 1'b0;
        step();
        step();
        load        = 1'b1;
        seed_in     = 10'h155;
        burst_start = 1'b1;
        burst_len   = 16'd4;
        step();
        load        = 1'b0;
        burst_start = 1'b0;
        tests_run++;
        if (out !== 10'h155 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_abort: got out=%h busy=%b done=%b expected 155 0 0", out, busy, done);
        end
        step();
        tests_run++;
        if (out !== 10'h155 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_abort_after: got out=%h busy=%b done=%b expected 155 0 0", out, busy, done);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        burst_start = 1'b1;
        burst_len   = 16'd10;
        step();
        burst_start = 1'b0;
        step();
        step();
        step();
        tests_run++;
        if (out !== 10'h007 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre: got out=%h busy=%b expected 007 1", out, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({out, busy, done, lockup} !== 13'h0) begin
            tests_failed++;
            $display("FAIL async_clear: got out=%h busy=%b done=%b lockup=%b expected all zero",
                     out, busy, done, lockup);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        tests_run++;
        if ({out, busy, done, lockup} !== 13'h0) begin
            tests_failed++;
            $display("FAIL async_release: got out=%h busy=%b done=%b lockup=%b expected all zero",
                     out, busy, done, lockup);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_period();
        test_burst();
        test_burst_ignore();
        test_lockup();
        test_load_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
